// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data RAM.
//   dmem_state_t   access sequencer states
//   WR_*           low-justified byte-mask encodings carried on wrType
//   lane_mask      byte enables for a mask at a given byte offset
//   is_misaligned  true when an access would cross a word boundary
//   byte_parity    even parity bit per byte of a 32-bit word
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACCESS,
        RESP
    } dmem_state_t;

    localparam logic [3:0] WR_NONE = 4'b0000;
    localparam logic [3:0] WR_B    = 4'b0001;
    localparam logic [3:0] WR_H    = 4'b0011;
    localparam logic [3:0] WR_W    = 4'b1111;

    // Upper lanes shifted out past bit 3 are dropped; such accesses are
    // caught by is_misaligned and never reach the RAM.
    function automatic logic [3:0] lane_mask(input logic [3:0] wr_type,
                                             input logic [1:0] off);
        return wr_type << off;
    endfunction

    function automatic logic is_misaligned(input logic [3:0] wr_type,
                                           input logic [1:0] off);
        return ((wr_type == WR_H) && (off == 2'd3)) ||
               ((wr_type == WR_W) && (off != 2'd0));
    endfunction

    function automatic logic [3:0] byte_parity(input logic [31:0] word);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i] = ^word[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for the data RAM.
//   wr_type_i   low-justified store mask (0000 = load)
//   off_i       byte offset within the word (addr[1:0])
//   wdata_i     low-justified store data
//   rword_i     raw word read from the RAM
//   be_o        per-byte write enables
//   wd_o        store data shifted into its lanes
//   rdata_o     read word right-justified by the byte offset, zero-filled
//   misalign_o  access crosses a word boundary
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [3:0]  wr_type_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wd_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [4:0] bit_off;

    assign bit_off    = {off_i, 3'b000};
    assign be_o       = lane_mask(wr_type_i, off_i);
    assign wd_o       = wdata_i << bit_off;
    assign rdata_o    = rword_i >> bit_off;
    assign misalign_o = is_misaligned(wr_type_i, off_i);

endmodule

// File: rtl/data_mem.sv
// data_mem: byte-addressed 32-bit data RAM with req/ack handshake and
// programmable wait states.
//   clk       rising-edge clock
//   rstN      asynchronous active-low reset (RAM contents are kept)
//   req       access request, held by the requester until ack
//   addr      byte address
//   wrType    0000 load, 0001 SB, 0011 SH, 1111 SW
//   wdata     low-justified store data
//   rdata     read word shifted right by 8*addr[1:0]
//   ack       one-cycle completion pulse
//   misalign  with ack: access crossed a word boundary, nothing written
//   parErr    with ack: parity mismatch on a load
// Optional build macro DMEM_PARITY_EN adds one even-parity bit per byte;
// without it parErr is tied low.
//
// state  | meaning
// IDLE   | waiting for req; request fields latched on acceptance
// BUSY   | inserting WAIT_CYCLES wait states
// ACCESS | RAM write or read-data capture happens on this edge
// RESP   | ack high; misalign/parErr valid
module data_mem
    import dmem_pkg::*;
#(
    parameter int SIZE        = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            req,
    input  logic [SIZE-1:0] addr,
    input  logic [3:0]      wrType,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            ack,
    output logic            misalign,
    output logic            parErr
);

    localparam int DEPTH = 2 ** (SIZE - 2);

    dmem_state_t      state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [SIZE-1:0]  addr_q, addr_d;
    logic [3:0]       wr_type_q, wr_type_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ack_q, ack_d;
    logic             misalign_q, misalign_d;
    logic             par_err_q, par_err_d;

    logic [31:0]      mem [DEPTH];
    logic [SIZE-3:0]  widx;
    logic [31:0]      rword;
    logic [3:0]       be;
    logic [31:0]      wd;
    logic [31:0]      rdata_aligned;
    logic             mis;
    logic             is_load;
    logic             mem_we;
    logic             par_bad;

    assign widx    = addr_q[SIZE-1:2];
    assign rword   = mem[widx];
    assign is_load = (wr_type_q == WR_NONE);
    assign mem_we  = (state_q == ACCESS) && !is_load && !mis;

    dmem_lane_align u_align (
        .wr_type_i  (wr_type_q),
        .off_i      (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .rword_i    (rword),
        .be_o       (be),
        .wd_o       (wd),
        .rdata_o    (rdata_aligned),
        .misalign_o (mis)
    );

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_PARITY_EN
    logic [3:0] par_q [DEPTH];
    logic [3:0] wd_par;

    assign wd_par  = byte_parity(wd);
    // All four lanes are checked, so a partly initialised word can flag.
    assign par_bad = |(byte_parity(rword) ^ par_q[widx]);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    par_q[widx][i] <= wd_par[i];
                end
            end
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wr_type_d  = wr_type_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ack_d      = 1'b0;
        misalign_d = misalign_q;
        par_err_d  = par_err_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d    = addr;
                    wr_type_d = wrType;
                    wdata_d   = wdata;
                    cnt_d     = 4'(WAIT_CYCLES);
                    state_d   = (WAIT_CYCLES > 0) ? BUSY : ACCESS;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d    = RESP;
                ack_d      = 1'b1;
                misalign_d = mis;
                par_err_d  = is_load && par_bad;
                if (mis) begin
                    rdata_d = 32'h0;
                end else if (is_load) begin
                    rdata_d = rdata_aligned;
                end
            end
            RESP: begin
                state_d = IDLE;
                // Flags are only meaningful alongside ack; drop them on the
                // way back to IDLE.
                misalign_d = 1'b0;
                par_err_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wr_type_q  <= WR_NONE;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            ack_q      <= 1'b0;
            misalign_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wr_type_q  <= wr_type_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            misalign_q <= misalign_d;
            par_err_q  <= par_err_d;
        end
    end

    assign rdata    = rdata_q;
    assign ack      = ack_q;
    assign misalign = misalign_q;
    assign parErr   = par_err_q;

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed bench for data_mem. Instance 0 has no wait states,
// instance 1 has three.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        rstn_s   [2];
    logic        req_s    [2];
    logic [11:0] addr_s   [2];
    logic [3:0]  wrtype_s [2];
    logic [31:0] wdata_s  [2];
    logic [31:0] rdata_s  [2];
    logic        ack_s    [2];
    logic        mis_s    [2];
    logic        pe_s     [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem #(.SIZE(12), .WAIT_CYCLES(0)) u_dut0 (
        .clk      (clk),
        .rstN     (rstn_s[0]),
        .req      (req_s[0]),
        .addr     (addr_s[0]),
        .wrType   (wrtype_s[0]),
        .wdata    (wdata_s[0]),
        .rdata    (rdata_s[0]),
        .ack      (ack_s[0]),
        .misalign (mis_s[0]),
        .parErr   (pe_s[0])
    );

    data_mem #(.SIZE(12), .WAIT_CYCLES(3)) u_dut1 (
        .clk      (clk),
        .rstN     (rstn_s[1]),
        .req      (req_s[1]),
        .addr     (addr_s[1]),
        .wrType   (wrtype_s[1]),
        .wdata    (wdata_s[1]),
        .rdata    (rdata_s[1]),
        .ack      (ack_s[1]),
        .misalign (mis_s[1]),
        .parErr   (pe_s[1])
    );

    typedef struct {
        logic [11:0] addr;
        logic [3:0]  wt;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // One complete handshake: latency counts falling edges after the edge
    // that sampled req, up to and including the one where ack is seen.
    task automatic do_access(input int d, input logic [11:0] a, input logic [3:0] wt,
                             input logic [31:0] wd, output logic [31:0] rd,
                             output logic mis, output logic pe, output int lat,
                             output logic ack_tail);
        lat = 0;
        rd  = 32'h0;
        mis = 1'b0;
        pe  = 1'b0;
        @(negedge clk);
        req_s[d]    = 1'b1;
        addr_s[d]   = a;
        wrtype_s[d] = wt;
        wdata_s[d]  = wd;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack_s[d]) begin
                lat = i + 1;
                rd  = rdata_s[d];
                mis = mis_s[d];
                pe  = pe_s[d];
                break;
            end
        end
        @(posedge clk);
        #1;
        req_s[d] = 1'b0;
        @(negedge clk);
        ack_tail = ack_s[d];
    endtask

    logic [31:0] rd;
    logic        mis, pe, tail, seen;
    int          lat;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rstn_s[d]   = 1'b0;
            req_s[d]    = 1'b0;
            addr_s[d]   = 12'h0;
            wrtype_s[d] = 4'h0;
            wdata_s[d]  = 32'h0;
        end

        //            addr    wt     wdata         exp rdata     mis
        vecs[0]  = '{12'h010, 4'hF, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{12'h010, 4'h0, 32'h00000000, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{12'h010, 4'hF, 32'h11223344, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{12'h013, 4'h1, 32'hFFFFFFAA, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{12'h010, 4'h0, 32'h00000000, 32'hAA223344, 1'b0};
        vecs[5]  = '{12'h013, 4'h0, 32'h00000000, 32'h000000AA, 1'b0};
        vecs[6]  = '{12'h011, 4'h0, 32'h00000000, 32'h00AA2233, 1'b0};
        vecs[7]  = '{12'h020, 4'hF, 32'h11223344, 32'h00AA2233, 1'b0};
        vecs[8]  = '{12'h023, 4'h3, 32'h0000BEEF, 32'h00000000, 1'b1};
        vecs[9]  = '{12'h020, 4'h0, 32'h00000000, 32'h11223344, 1'b0};
        vecs[10] = '{12'h022, 4'hF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[11] = '{12'h020, 4'h0, 32'h00000000, 32'h11223344, 1'b0};
        vecs[12] = '{12'h022, 4'h3, 32'h0000BEEF, 32'h11223344, 1'b0};
        vecs[13] = '{12'h022, 4'h0, 32'h00000000, 32'h0000BEEF, 1'b0};
        vecs[14] = '{12'h021, 4'h1, 32'hFFFFFF77, 32'h0000BEEF, 1'b0};
        vecs[15] = '{12'h020, 4'h0, 32'h00000000, 32'hBEEF7744, 1'b0};
        vecs[16] = '{12'h020, 4'h3, 32'h1234CAFE, 32'hBEEF7744, 1'b0};
        vecs[17] = '{12'h020, 4'h0, 32'h00000000, 32'hBEEFCAFE, 1'b0};
        vecs[18] = '{12'hFFC, 4'hF, 32'h00000000, 32'hBEEFCAFE, 1'b0};
        vecs[19] = '{12'hFFF, 4'h1, 32'h0000005A, 32'hBEEFCAFE, 1'b0};
        vecs[20] = '{12'hFFC, 4'h0, 32'h00000000, 32'h5A000000, 1'b0};
        vecs[21] = '{12'hFFD, 4'h0, 32'h00000000, 32'h005A0000, 1'b0};
        vecs[22] = '{12'h021, 4'h3, 32'h0000ABCD, 32'h005A0000, 1'b0};
        vecs[23] = '{12'h020, 4'h0, 32'h00000000, 32'hBEABCDFE, 1'b0};

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_rdata%0d", d), rdata_s[d], 32'h0);
            chk($sformatf("rst_ack%0d", d), 32'(ack_s[d]), 32'h0);
            chk($sformatf("rst_mis%0d", d), 32'(mis_s[d]), 32'h0);
            chk($sformatf("rst_pe%0d", d), 32'(pe_s[d]), 32'h0);
        end
        rstn_s[0] = 1'b1;
        rstn_s[1] = 1'b1;

        // Table on the zero-wait instance.
        for (int v = 0; v < 24; v++) begin
            do_access(0, vecs[v].addr, vecs[v].wt, vecs[v].wd, rd, mis, pe, lat, tail);
            chk($sformatf("v%0d_lat", v), 32'(lat), 32'd2);
            chk($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rd);
            chk($sformatf("v%0d_mis", v), 32'(mis), 32'(vecs[v].exp_mis));
            chk($sformatf("v%0d_pe", v), 32'(pe), 32'h0);
            chk($sformatf("v%0d_ack_1cyc", v), 32'(tail), 32'h0);
        end

        // Parity: corrupt lane 0 parity of word 0x030 behind the design's back.
        do_access(0, 12'h030, 4'hF, 32'h01020304, rd, mis, pe, lat, tail);
`ifdef DMEM_PARITY_EN
        u_dut0.par_q[12] = u_dut0.par_q[12] ^ 4'b0001;
`endif
        do_access(0, 12'h030, 4'h0, 32'h0, rd, mis, pe, lat, tail);
        chk("par_rdata", rd, 32'h01020304);
`ifdef DMEM_PARITY_EN
        chk("par_err", 32'(pe), 32'h1);
`else
        chk("par_err", 32'(pe), 32'h0);
`endif

        // Wait states: inputs change mid-operation and req stays high through
        // RESP; only the values sampled in IDLE may take effect.
        do_access(1, 12'h104, 4'hF, 32'h0BADF00D, rd, mis, pe, lat, tail);
        chk("w3_prewrite_lat", 32'(lat), 32'd5);
        @(negedge clk);
        req_s[1] = 1'b1; addr_s[1] = 12'h100; wrtype_s[1] = 4'hF; wdata_s[1] = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        addr_s[1] = 12'h104; wdata_s[1] = 32'h12345678;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack_s[1]) begin
                lat = i + 1;
                break;
            end
        end
        chk("w3_lat", 32'(lat), 32'd5);
        @(posedge clk);
        #1;
        req_s[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | ack_s[1];
        end
        chk("w3_no_reack", 32'(seen), 32'h0);
        do_access(1, 12'h100, 4'h0, 32'h0, rd, mis, pe, lat, tail);
        chk("w3_rd100", rd, 32'hA5A5A5A5);
        chk("w3_rd_lat", 32'(lat), 32'd5);
        chk("w3_ack_1cyc", 32'(tail), 32'h0);
        do_access(1, 12'h104, 4'h0, 32'h0, rd, mis, pe, lat, tail);
        chk("w3_rd104", rd, 32'h0BADF00D);

        // Reset during BUSY of a store.
        do_access(1, 12'h040, 4'hF, 32'h55667788, rd, mis, pe, lat, tail);
        do_access(1, 12'h000, 4'h0, 32'h0, rd, mis, pe, lat, tail);
        @(negedge clk);
        req_s[1] = 1'b1; addr_s[1] = 12'h040; wrtype_s[1] = 4'hF; wdata_s[1] = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        rstn_s[1] = 1'b0;
        req_s[1]  = 1'b0;
        #1;
        chk("rst_mid_rdata", rdata_s[1], 32'h0);
        chk("rst_mid_ack", 32'(ack_s[1]), 32'h0);
        chk("rst_mid_mis", 32'(mis_s[1]), 32'h0);
        chk("rst_mid_pe", 32'(pe_s[1]), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | ack_s[1];
        end
        rstn_s[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | ack_s[1];
        end
        chk("rst_mid_no_ack", 32'(seen), 32'h0);
        do_access(1, 12'h040, 4'h0, 32'h0, rd, mis, pe, lat, tail);
        chk("rst_mid_word", rd, 32'h55667788);
        chk("rst_mid_lat", 32'(lat), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
